// File: rtl/see_merge_rr_pkg.sv
// see_merge_rr_pkg: shared widths, channel index and status record for the N-channel merger
package see_merge_rr_pkg;
    localparam int MAX_CH_W = 8;
    localparam int MAX_LVL_W = 8;
    localparam int MAX_CNT_W = 32;
    typedef logic [MAX_CH_W-1:0] ch_idx_t;
    typedef struct packed {
        logic [MAX_LVL_W-1:0] lvl;
        logic [MAX_CNT_W-1:0] cnt;
    } ch_status_t;
    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic int lvl_w(input int d);
        return $clog2(d) + 1;
    endfunction
    function automatic ch_status_t pack_status(input logic [MAX_LVL_W-1:0] lvl, input logic [MAX_CNT_W-1:0] cnt);
        return '{lvl: lvl, cnt: cnt};
    endfunction
endpackage

// File: rtl/see_merge_rr_if.sv
// see_merge_rr_if: producer-side and consumer-side rdy/vld bundle of the merger
interface see_merge_rr_if
    import see_merge_rr_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32
);
    localparam int CH_W = ch_w(NUM_CH);
    logic [NUM_CH-1:0] in_vld;
    logic [NUM_CH-1:0] in_rdy;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic out_vld;
    logic out_rdy;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0] out_ch;
    modport slave (input in_vld, in_data, out_rdy, output in_rdy, out_vld, out_data, out_ch);
    modport master (output in_vld, in_data, out_rdy, input in_rdy, out_vld, out_data, out_ch);
endinterface

// File: rtl/see_merge_rr_fifo.sv
// see_merge_rr_fifo: per-channel synchronous FIFO with full/empty/level, push and pop in one cycle
module see_merge_rr_fifo
    import see_merge_rr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DATA_W = 32,
    parameter int LVL_W = lvl_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  lvl
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [LVL_W-2:0] wp, rp;
    logic wr, rd;
    assign full = lvl == LVL_W'(DEPTH);
    assign empty = lvl == '0;
    assign wr = push && !full;
    assign rd = pop && !empty;
    assign dout = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            lvl <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            lvl <= lvl + LVL_W'(wr) - LVL_W'(rd);
        end
    end
    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;
endmodule

// File: rtl/see_merge_rr.sv
// see_merge_rr: N-channel rdy/vld merger, per-channel FIFOs, masked round-robin into one registered tagged stream
module see_merge_rr
    import see_merge_rr_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int CH_W = ch_w(NUM_CH),
    localparam int LVL_W = lvl_w(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    see_merge_rr_if.slave           bus,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    cnt_clr,
    output logic [NUM_CH*LVL_W-1:0] fifo_lvl,
    output logic [NUM_CH*CNT_W-1:0] beat_cnt
);
    logic [NUM_CH-1:0] full, empty, elig, pop;
    logic [DATA_W-1:0] dout [NUM_CH];
    logic [CH_W-1:0] rr_ptr, gnt, och;
    logic [DATA_W-1:0] odata;
    logic load, ovld;
    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [CNT_W-1:0] cnt;
            see_merge_rr_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .LVL_W(LVL_W)) u_fifo (
                .clk(clk), .rst(rst), .push(bus.in_vld[c]), .din(bus.in_data[c*DATA_W +: DATA_W]),
                .pop(pop[c]), .dout(dout[c]), .full(full[c]), .empty(empty[c]),
                .lvl(fifo_lvl[c*LVL_W +: LVL_W])
            );
            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt <= '0;
                else if (cnt_clr) cnt <= '0;
                else if (pop[c] && cnt != '1) cnt <= cnt + 1'b1;
            end
            assign beat_cnt[c*CNT_W +: CNT_W] = cnt;
        end
    endgenerate
    assign elig = ~empty & ch_en;
    assign load = (!ovld || bus.out_rdy) && |elig;
    assign pop = load ? NUM_CH'(1) << gnt : '0;
    // Descending scan so the smallest offset past rr_ptr is the last (winning) assignment
    always_comb begin
        gnt = rr_ptr;
        for (int i = NUM_CH; i >= 1; i--)
            if (elig[(int'(rr_ptr) + i) % NUM_CH]) gnt = CH_W'((int'(rr_ptr) + i) % NUM_CH);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovld <= 1'b0;
            odata <= '0;
            och <= '0;
            rr_ptr <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            ovld <= 1'b1;
            odata <= dout[gnt];
            och <= gnt;
            rr_ptr <= gnt;
        end else if (bus.out_rdy) begin
            ovld <= 1'b0;
        end
    end
    assign bus.in_rdy = ~full;
    assign bus.out_vld = ovld;
    assign bus.out_data = odata;
    assign bus.out_ch = och;
endmodule
